// File: rtl/clk_tick_monitor.sv
// Divided-clock consumer: synchronizes a slow clock, emits one-cycle ticks,
// measures the period and flags fast/stalled clocks. Optional: CLK_MON_GLITCH_FILTER_EN.
module clk_tick_monitor #(
  parameter int CNT_W       = 20,
  parameter int PERIOD_MIN  = 523264,
  parameter int PERIOD_MAX  = 525312,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk100mhz,
  input  logic             rst_n,
  input  logic             slow_clk_in,
  input  logic             clr_fault,
  output logic             tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ACQ   = 2'b01,
    S_LOCK  = 2'b10,
    S_FAULT = 2'b11
  } state_t;

  localparam logic [1:0]       C_NONE = 2'b00;
  localparam logic [1:0]       C_FAST = 2'b01;
  localparam logic [1:0]       C_SLOW = 2'b10;
  localparam logic [CNT_W:0]   MIN_W  = (CNT_W+1)'(PERIOD_MIN);
  localparam logic [CNT_W:0]   MAX_W  = (CNT_W+1)'(PERIOD_MAX);
  localparam logic [CNT_W-1:0] TMO    = CNT_W'(PERIOD_MAX);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic                   acc;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             pvalid_q, pvalid_d;
  logic [1:0]       code_q, code_d;
  logic             tick_q;
  logic [CNT_W:0]   meas;
  logic [CNT_W-1:0] meas_sat;
  logic             timeout;

  always_ff @(posedge clk100mhz) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk_in};
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef CLK_MON_GLITCH_FILTER_EN
  // Count consecutive high samples; accept once the third high sample arrives.
  logic [1:0] hcnt_q;

  always_ff @(posedge clk100mhz) begin
    if (!rst_n)              hcnt_q <= '0;
    else if (!sync_s)        hcnt_q <= '0;
    else if (hcnt_q != 2'd3) hcnt_q <= hcnt_q + 2'd1;
  end

  assign acc = sync_s && (hcnt_q == 2'd2);
`else
  logic prev_q;

  always_ff @(posedge clk100mhz) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= sync_s;
  end

  assign acc = sync_s && !prev_q;
`endif

  // Extra bit so a saturated counter in FAULT cannot wrap the measurement.
  assign meas     = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign meas_sat = meas[CNT_W] ? '1 : meas[CNT_W-1:0];
  assign timeout  = (cnt_q == TMO);

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    period_d = period_q;
    pvalid_d = pvalid_q;
    cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    if (acc) cnt_d = '0;

    case (state_q)
      S_IDLE: begin
        if (acc) begin
          state_d = S_ACQ;
        end else if (timeout) begin
          state_d = S_FAULT;
          code_d  = C_SLOW;
        end
      end
      S_ACQ, S_LOCK: begin
        // An edge wins over a coincident timeout; it then measures PERIOD_MAX+1.
        if (acc) begin
          period_d = meas_sat;
          pvalid_d = 1'b1;
          if (meas < MIN_W) begin
            state_d = S_FAULT;
            code_d  = C_FAST;
          end else if (meas > MAX_W) begin
            state_d = S_FAULT;
            code_d  = C_SLOW;
          end else begin
            state_d = S_LOCK;
          end
        end else if (timeout) begin
          state_d = S_FAULT;
          code_d  = C_SLOW;
        end
      end
      S_FAULT: begin
        if (clr_fault) begin
          state_d = S_IDLE;
          code_d  = C_NONE;
          cnt_d   = '0;
        end else if (acc) begin
          period_d = meas_sat;
          pvalid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk100mhz) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      pvalid_q <= 1'b0;
      code_q   <= C_NONE;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pvalid_q <= pvalid_d;
      code_q   <= code_d;
      tick_q   <= acc;
    end
  end

  assign tick         = tick_q;
  assign period       = period_q;
  assign period_valid = pvalid_q;
  assign fault_code   = code_q;
  assign state        = state_q;
  assign fault        = (state_q == S_FAULT);

endmodule

// File: tb/tb_clk_tick_monitor.sv
// Directed bench for clk_tick_monitor with PERIOD_MIN=90, PERIOD_MAX=110, CNT_W=8.
module tb_clk_tick_monitor;
  localparam int CNT_W = 8;
  localparam int PMIN  = 90;
  localparam int PMAX  = 110;
  localparam int SYNC  = 2;
`ifdef CLK_MON_GLITCH_FILTER_EN
  localparam int LAT = SYNC + 3;
`else
  localparam int LAT = SYNC + 1;
`endif

  logic             clk100mhz = 1'b0;
  logic             rst_n = 1'b0;
  logic             slow_clk_in = 1'b0;
  logic             clr_fault = 1'b0;
  logic             tick;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             fault;
  logic [1:0]       fault_code;
  logic [1:0]       state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk100mhz = ~clk100mhz;

  clk_tick_monitor #(
    .CNT_W(CNT_W), .PERIOD_MIN(PMIN), .PERIOD_MAX(PMAX), .SYNC_STAGES(SYNC)
  ) dut (
    .clk100mhz(clk100mhz), .rst_n(rst_n), .slow_clk_in(slow_clk_in),
    .clr_fault(clr_fault), .tick(tick), .period(period),
    .period_valid(period_valid), .fault(fault), .fault_code(fault_code),
    .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int st, input int per,
                         input int pv, input int code);
    chk({tag, ".state"},  32'(state),        32'(st));
    chk({tag, ".fault"},  32'(fault),        32'(st == 3));
    chk({tag, ".period"}, 32'(period),       32'(per));
    chk({tag, ".pvalid"}, 32'(period_valid), 32'(pv));
    chk({tag, ".code"},   32'(fault_code),   32'(code));
  endtask

  task automatic cyc();
    @(posedge clk100mhz);
    #1;
  endtask

  // Raise the input and run until the tick should be visible.
  task automatic rise(input bit clr);
    slow_clk_in = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      if (clr && i == LAT) clr_fault = 1'b1;
      cyc();
      clr_fault = 1'b0;
      chk("tick_lat", 32'(tick), 32'(i == LAT));
    end
  endtask

  // Remaining cycles of a period: no tick, input drops after 20 cycles.
  task automatic gap(input int n);
    for (int i = 1; i <= n; i++) begin
      cyc();
      chk("tick_idle", 32'(tick), 32'd0);
      if (i == 20) slow_clk_in = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) cyc();
    chk_out("reset", 0, 0, 0, 0);
    chk("reset.tick", 32'(tick), 32'd0);
    rst_n = 1'b1;

    rise(1'b0);          chk_out("acq",        1, 0,   0, 0);
    gap(100 - LAT); rise(1'b0); chk_out("lock1",      2, 100, 1, 0);
    gap(100 - LAT); rise(1'b0); chk_out("lock2",      2, 100, 1, 0);
    gap(60 - LAT);  rise(1'b0); chk_out("fast",       3, 60,  1, 1);
    gap(100 - LAT); rise(1'b0); chk_out("fault_hold", 3, 100, 1, 1);
    gap(100 - LAT); rise(1'b1); chk_out("clr_edge",   0, 100, 1, 0);
    gap(100 - LAT); rise(1'b0); chk_out("idle_acq",   1, 100, 1, 0);
    gap(90 - LAT);  rise(1'b0); chk_out("min90",      2, 90,  1, 0);
    gap(110 - LAT); rise(1'b0); chk_out("max110",     2, 110, 1, 0);
    gap(111 - LAT); rise(1'b0); chk_out("p111",       3, 111, 1, 2);

    gap(40);
    clr_fault = 1'b1; cyc(); clr_fault = 1'b0;
    chk_out("clr", 0, 111, 1, 0);
    rise(1'b0);                 chk_out("acq2",  1, 111, 1, 0);
    gap(100 - LAT); rise(1'b0); chk_out("lock3", 2, 100, 1, 0);

    // Stall: fault appears exactly 111 cycles after the last tick.
    for (int i = 1; i <= 111; i++) begin
      cyc();
      if (i == 20) slow_clk_in = 1'b0;
      if (i == 110) chk_out("pre_stall", 2, 100, 1, 0);
    end
    chk_out("stall", 3, 100, 1, 2);

    clr_fault = 1'b1; cyc(); clr_fault = 1'b0;
    chk("clr2.state", 32'(state), 32'd0);
    rise(1'b0);
    gap(100 - LAT); rise(1'b0); chk_out("lock4", 2, 100, 1, 0);
    for (int i = 1; i <= 50; i++) begin
      cyc();
      if (i == 20) slow_clk_in = 1'b0;
    end
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk_out("rst_mid", 0, 0, 0, 0);
    chk("rst_mid.tick", 32'(tick), 32'd0);
    rise(1'b0); chk_out("post_rst", 1, 0, 0, 0);

`ifdef CLK_MON_GLITCH_FILTER_EN
    gap(40);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    slow_clk_in = 1'b1; cyc(); cyc(); slow_clk_in = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      chk("glitch.tick", 32'(tick), 32'd0);
    end
    chk_out("glitch", 0, 0, 0, 0);
    rise(1'b0);                 chk_out("gf_acq",  1, 0,   0, 0);
    gap(100 - LAT); rise(1'b0); chk_out("gf_lock", 2, 100, 1, 0);
    gap(100 - LAT); rise(1'b0); chk_out("gf_lock2", 2, 100, 1, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
